imm_gen_pipe: RTL

//  Parametrised, pipelined immediate generator for the ID stage.
//  - Extracts and sign/zero-extends immediates (U/J/I/B/S/shamt) from the instruction word to XLEN bits.
//  - 1..2 internal register stages, each with a valid bit and stall/flush control.
//  - Flags unencoded select codes instead of silently holding the previous value.

---
 rtl/imm_gen_pipe_if.sv | 24 ++
 rtl/imm_gen_pipe.sv | 116 +++++++++++
 2 files changed

// File: rtl/imm_gen_pipe_if.sv
// Request/response bundle for the pipelined immediate generator.
// The master drives instruction, select and pipeline control; the slave returns the immediate.
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic [31:0]     inst;
  logic [3:0]      imm_sel;
  logic            in_valid;
  logic            stall;
  logic            flush;
  logic [XLEN-1:0] imm_ext;
  logic            out_valid;
  logic            illegal_sel;

  modport master (
    output inst, imm_sel, in_valid, stall, flush,
    input  imm_ext, out_valid, illegal_sel
  );

  modport slave (
    input  inst, imm_sel, in_valid, stall, flush,
    output imm_ext, out_valid, illegal_sel
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// ID-stage immediate generator: combinational extract/extend core followed by
// 1..2 register stages with valid, stall and flush; outputs come from the last stage.
module imm_gen_pipe #(
  parameter int XLEN        = 32,
  parameter int PIPE_STAGES = 1
) (
  input  logic         CLK,
  input  logic         RESETn,
  imm_gen_pipe_if.slave bus
);

  generate
    if ((XLEN != 32 && XLEN != 64) || (PIPE_STAGES != 1 && PIPE_STAGES != 2)) begin : g_bad_param
      $error("imm_gen_pipe: XLEN must be 32 or 64 and PIPE_STAGES must be 1 or 2");
    end
    if ($bits(bus.imm_ext) != XLEN) begin : g_bad_if
      $error("imm_gen_pipe: interface XLEN does not match module XLEN");
    end
  endgenerate

  localparam bit IS_64 = (XLEN == 64);

  logic [31:0]     inst;
  logic [3:0]      imm_sel;
  logic            ext_bit;
  logic [63:0]     wide_imm;
  logic            core_illegal;
  logic [XLEN-1:0] core_imm;
  logic            unused_bits;

  assign inst    = bus.inst;
  assign imm_sel = bus.imm_sel;

  // Every signed field has its sign in inst[31]; zero-extend forces the fill to 0.
  assign ext_bit = inst[31] & ~imm_sel[3];

  always_comb begin
    wide_imm     = 64'h0;
    core_illegal = 1'b0;
    case (imm_sel[2:0])
      3'b000:  wide_imm = {{32{inst[31]}}, inst[31:12], 12'h000};
      3'b001:  wide_imm = {{43{ext_bit}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      3'b010:  wide_imm = {{52{ext_bit}}, inst[31:20]};
      3'b011:  wide_imm = {{51{ext_bit}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      3'b100:  wide_imm = {{52{ext_bit}}, inst[31:25], inst[11:7]};
      3'b101:  wide_imm = IS_64 ? {58'h0, inst[25:20]} : {59'h0, inst[24:20]};
      default: begin
        wide_imm     = 64'h0;
        core_illegal = 1'b1;
      end
    endcase
  end

  // Built at 64 bits and truncated so the same expressions serve both widths.
  assign core_imm = wide_imm[XLEN-1:0];

  // Opcode bits and, for XLEN=32, the upper half of the wide result are intentionally dropped.
  assign unused_bits = ^{wide_imm, inst[6:0]};

  // Element k is the input of stage k; element PIPE_STAGES is the last stage output.
  logic [XLEN-1:0] chain_data  [PIPE_STAGES+1];
  logic            chain_valid [PIPE_STAGES+1];
  logic            chain_ill   [PIPE_STAGES+1];

  assign chain_data[0]  = core_imm;
  assign chain_valid[0] = bus.in_valid;
  assign chain_ill[0]   = core_illegal;

  genvar gi;
  generate
    for (gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
      logic [XLEN-1:0] data_q, data_d;
      logic            valid_q, valid_d;
      logic            ill_q, ill_d;

      always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ill_d   = ill_q;
        if (bus.flush) begin
          data_d  = '0;
          valid_d = 1'b0;
          ill_d   = 1'b0;
        end else if (!bus.stall) begin
          valid_d = chain_valid[gi];
          // Payload only moves with a valid entry; bubbles leave the old data in place.
          if (chain_valid[gi]) begin
            data_d = chain_data[gi];
            ill_d  = chain_ill[gi];
          end
        end
      end

      always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
          data_q  <= '0;
          valid_q <= 1'b0;
          ill_q   <= 1'b0;
        end else begin
          data_q  <= data_d;
          valid_q <= valid_d;
          ill_q   <= ill_d;
        end
      end

      assign chain_data[gi+1]  = data_q;
      assign chain_valid[gi+1] = valid_q;
      assign chain_ill[gi+1]   = ill_q;
    end
  endgenerate

  assign bus.imm_ext     = chain_data[PIPE_STAGES];
  assign bus.out_valid   = chain_valid[PIPE_STAGES];
  assign bus.illegal_sel = chain_ill[PIPE_STAGES];

endmodule
